// File: rtl/morse_player.sv
`default_nettype none
// ============================================================================
// morse_player : replays stored morse code words as timed tone pulses
// Revision     : 1.0
// ============================================================================
module morse_player #(
  parameter int DOT_UNITS      = 1,
  parameter int DASH_UNITS     = 3,
  parameter int SYM_GAP_UNITS  = 1,
  parameter int WORD_GAP_UNITS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] count,
  output logic [3:0] ram_addr,
  input  logic [9:0] ram_q,
  output logic       tone,
  output logic       busy,
  output logic       done,
  output logic [3:0] cur_word
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SYM, S_ON, S_SGAP, S_WGAP, S_FIN
  } state_t;

  localparam logic [7:0] c_dot   = 8'(DOT_UNITS);
  localparam logic [7:0] c_dash  = 8'(DASH_UNITS);
  localparam logic [7:0] c_sgap  = 8'(SYM_GAP_UNITS);
  localparam logic [7:0] c_wgap  = 8'(WORD_GAP_UNITS);

  state_t     r_state;
  logic [9:0] r_shift;
  logic [2:0] r_sym_idx;
  logic [7:0] r_units;
  logic [3:0] r_count;

  logic w_last_tick;
  logic w_next_end;

  // A phase ends on the tick that brings the unit counter to zero.
  assign w_last_tick = tick && (r_units <= 8'd1);
  // Low bit of a symbol is set only for dot (01) and dash (11).
  assign w_next_end  = (r_sym_idx == 3'd4) || !r_shift[6];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_sym_idx <= '0;
      r_units   <= '0;
      r_count   <= '0;
      ram_addr  <= '0;
      cur_word  <= '0;
      tone      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (stop && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      tone    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= count;
            if (count == 4'd0) begin
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              ram_addr <= '0;
              cur_word <= '0;
              busy     <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift   <= ram_q;
          r_sym_idx <= '0;
          r_state   <= S_SYM;
        end
        S_SYM: begin
          if (r_shift[8] && (r_sym_idx != 3'd5)) begin
            tone    <= 1'b1;
            r_units <= r_shift[9] ? c_dash : c_dot;
            r_state <= S_ON;
          end else begin
            tone    <= 1'b0;
            r_units <= c_wgap;
            r_state <= S_WGAP;
          end
        end
        S_ON: begin
          if (tick) begin
            r_units <= r_units - 8'd1;
            if (w_last_tick) begin
              tone      <= 1'b0;
              r_shift   <= {r_shift[7:0], 2'b00};
              r_sym_idx <= r_sym_idx + 3'd1;
              if (w_next_end) begin
                r_units <= c_wgap;
                r_state <= S_WGAP;
              end else begin
                r_units <= c_sgap;
                r_state <= S_SGAP;
              end
            end
          end
        end
        S_SGAP: begin
          if (tick) begin
            r_units <= r_units - 8'd1;
            if (w_last_tick) r_state <= S_SYM;
          end
        end
        S_WGAP: begin
          if (tick) begin
            r_units <= r_units - 8'd1;
            if (w_last_tick) begin
              if (cur_word == (r_count - 4'd1)) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= S_FIN;
              end else begin
                ram_addr <= ram_addr + 4'd1;
                cur_word <= cur_word + 4'd1;
                r_state  <= S_FETCH;
              end
            end
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          tone    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_player.sv
`default_nettype none
// ============================================================================
// tb_morse_player : randomized bench with a tone-segment reference model
// Revision        : 1.0
// ============================================================================
module tb_morse_player;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tick;
  logic       start;
  logic       stop;
  logic [3:0] count;
  logic [3:0] ram_addr;
  logic [9:0] ram_q;
  logic       tone;
  logic       busy;
  logic       done;
  logic [3:0] cur_word;

  logic [9:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  int tick_min = 4;
  int tick_max = 4;
  int tick_cd  = 0;
  bit tick_en  = 1'b1;

  bit rec = 1'b0;
  int done_total = 0;
  int busy_bad = 0;
  int rises = 0;
  logic prev_tone = 1'b0;
  int run_lvl[$];
  int run_len[$];
  int run_word[$];
  int run_addr[$];
  int exp_lvl[$];
  int exp_len[$];
  int exp_word[$];

  always #5 clock = ~clock;

  morse_player dut (
    .clock    (clock),
    .resetn   (resetn),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .tone     (tone),
    .busy     (busy),
    .done     (done),
    .cur_word (cur_word)
  );

  always_ff @(posedge clock) ram_q <= mem[ram_addr];

  // Segment recorder: ticks are attributed to the tone level present in their cycle.
  always @(negedge clock) begin
    if (done) done_total++;
    if (rec) begin
      if (!done && !busy) busy_bad++;
      if (tone && !prev_tone) rises++;
      if (tick) begin
        if (run_lvl.size() == 0 || run_lvl[run_lvl.size()-1] != int'(tone)) begin
          run_lvl.push_back(int'(tone));
          run_len.push_back(1);
          run_word.push_back(int'(cur_word));
          run_addr.push_back(int'(ram_addr));
        end else begin
          run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
      end
    end
    prev_tone = tone;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (tick_en && tick_cd == 0) begin
      tick    = 1'b1;
      tick_cd = $urandom_range(tick_max, tick_min) - 1;
    end else begin
      tick = 1'b0;
      if (tick_cd > 0) tick_cd--;
    end
  endtask

  // Start is raised in a tick cycle so no tick lands in the fetch/load/decode cycles.
  task automatic launch();
    int n = 0;
    step();
    while (tick !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    start = 1'b1;
  endtask

  task automatic push_seg(input int lvl, input int len, input int w);
    if (exp_lvl.size() != 0 && exp_lvl[exp_lvl.size()-1] == lvl) begin
      exp_len[exp_len.size()-1] = exp_len[exp_len.size()-1] + len;
    end else begin
      exp_lvl.push_back(lvl);
      exp_len.push_back(len);
      exp_word.push_back(w);
    end
  endtask

  // Expected tone waveform in tick units, straight from the word-format rules.
  task automatic build_expect(input int n);
    int sym, nxt;
    exp_lvl.delete();
    exp_len.delete();
    exp_word.delete();
    for (int w = 0; w < n; w++) begin
      for (int i = 0; i < 5; i++) begin
        sym = (int'(mem[w]) >> (8 - 2*i)) & 3;
        if (sym == 0 || sym == 2) begin
          push_seg(0, 3, w);
          break;
        end
        push_seg(1, (sym == 3) ? 3 : 1, w);
        if (i == 4) begin
          push_seg(0, 3, w);
        end else begin
          nxt = (int'(mem[w]) >> (6 - 2*i)) & 3;
          if (nxt == 1 || nxt == 3) push_seg(0, 1, w);
        end
      end
    end
  endtask

  task automatic play(input int n, input int gmin, input int gmax, input bit junk, input bit hold);
    int budget = 0;
    int base_done;
    int hold_bad = 0;
    int n_on = 0;
    bit held = 1'b0;
    tick_min = gmin;
    tick_max = gmax;
    build_expect(n);
    run_lvl.delete();
    run_len.delete();
    run_word.delete();
    run_addr.delete();
    rises = 0;
    busy_bad = 0;
    base_done = done_total;
    count = 4'(n);
    launch();
    step();
    start = 1'b0;
    rec = 1'b1;
    while (budget < 20000) begin
      @(negedge clock);
      #1;
      if (done_total != base_done) break;
      if (hold && !held && tone && run_lvl.size() != 0 &&
          run_lvl[run_lvl.size()-1] == 1 && run_len[run_len.size()-1] == 1) begin
        held = 1'b1;
        tick_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
          step();
          if (tone !== 1'b1) hold_bad++;
        end
        tick_en = 1'b1;
      end
      step();
      if (junk) begin
        start = ($urandom_range(0, 5) == 0);
        count = 4'($urandom);
      end
      budget++;
    end
    start = 1'b0;
    rec = 1'b0;
    check_value("run_finished", 32'(budget < 20000), 1);
    check_value("num_segments", run_lvl.size(), exp_lvl.size());
    for (int i = 0; i < exp_lvl.size() && i < run_lvl.size(); i++) begin
      check_value($sformatf("seg%0d_level", i), run_lvl[i], exp_lvl[i]);
      check_value($sformatf("seg%0d_ticks", i), run_len[i], exp_len[i]);
      if (exp_lvl[i] == 1) begin
        n_on++;
        check_value($sformatf("seg%0d_cur_word", i), run_word[i], exp_word[i]);
        check_value($sformatf("seg%0d_ram_addr", i), run_addr[i], exp_word[i]);
      end
    end
    check_value("tone_rises", rises, n_on);
    check_value("busy_during_run", busy_bad, 0);
    for (int k = 0; k < 6; k++) step();
    check_value("done_once", done_total - base_done, 1);
    check_value("idle_outputs", {tone, busy, done}, 3'b000);
    if (hold) begin
      check_value("hold_reached", 32'(held), 1);
      check_value("hold_tone_high", hold_bad, 0);
    end
  endtask

  initial begin
    int n, base, bad;
    resetn = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    count = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 10'h000;
    #1;
    check_value("reset_outputs", {tone, busy, done, ram_addr, cur_word}, 11'd0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Stop while idle must be harmless.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_value("stop_in_idle", {tone, busy, done}, 3'b000);

    // Dot, dash, word gap.
    mem[0] = 10'b01_11_00_00_00;
    play(1, 4, 4, 1'b0, 1'b0);

    // count==0: done one cycle after start, never busy.
    count = 4'd0;
    base = done_total;
    launch();
    step();
    start = 1'b0;
    check_value("zero_done_pulse", {done, busy, tone}, 3'b100);
    step();
    check_value("zero_done_single", {done, busy}, 2'b00);
    check_value("zero_done_count", done_total - base, 1);

    // Dashes, an empty word, dots.
    mem[0] = 10'b11_11_11_11_11;
    mem[1] = 10'b00_00_00_00_00;
    mem[2] = 10'b01_01_01_01_01;
    play(3, 4, 4, 1'b0, 1'b0);

    // Tick stall in the middle of a dash.
    mem[0] = 10'b11_00_00_00_00;
    play(1, 4, 4, 1'b0, 1'b1);

    // Stop during the second word's tone.
    mem[0] = 10'b01_11_00_00_00;
    mem[1] = 10'b11_11_11_11_11;
    count = 4'd2;
    tick_min = 4;
    tick_max = 6;
    launch();
    step();
    start = 1'b0;
    n = 0;
    while (!(tone === 1'b1 && cur_word == 4'd1) && n < 5000) begin
      step();
      n++;
    end
    check_value("stop_reached_word1", 32'(n < 5000), 1);
    step();
    base = done_total;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_value("stop_outputs", {tone, busy}, 2'b00);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tone !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_value("stop_stays_idle", bad, 0);
    check_value("stop_no_done", done_total - base, 0);
    play(2, 4, 6, 1'b0, 1'b0);

    // Asynchronous reset in the symbol gap of the second word.
    mem[0] = 10'b01_01_01_01_01;
    mem[1] = 10'b01_01_01_01_01;
    count = 4'd2;
    launch();
    step();
    start = 1'b0;
    n = 0;
    while (!(tone === 1'b1 && cur_word == 4'd1) && n < 5000) begin
      step();
      n++;
    end
    while (tone === 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check_value("reset_reached_sgap", 32'(n < 5000), 1);
    base = done_total;
    #2 resetn = 1'b0;
    #1;
    check_value("async_reset_outputs", {tone, busy, done, ram_addr, cur_word}, 11'd0);
    repeat (2) step();
    check_value("reset_held_outputs", {tone, busy, done}, 3'b000);
    @(negedge clock);
    resetn = 1'b1;
    check_value("reset_no_done", done_total - base, 0);
    play(2, 4, 7, 1'b1, 1'b0);

    // Randomized words, lengths and tick spacing.
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 15 : $urandom_range(1, 15);
      for (int i = 0; i < 16; i++) mem[i] = 10'($urandom);
      play(n, 4, 7, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
